// File: rtl/sampler_pkg.sv
// sampler_pkg: shared FSM state type and default widths for the sample reader.
package sampler_pkg;
  localparam int DEF_CNT_BITS = 16;
  localparam int DEF_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, OUT, DONE} state_t;
endpackage

// File: rtl/rd_addr_counter.sv
// rd_addr_counter: read address and remaining-sample tracker with modular wrap.
module rd_addr_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] load_addr,
  input  logic [W-1:0] load_count,
  output logic [W-1:0] addr,
  output logic         last
);
  logic [W-1:0] remaining;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr <= '0;
      remaining <= '0;
    end else if (load) begin
      addr <= load_addr;
      remaining <= load_count;
    end else if (step) begin
      addr <= addr + W'(1);
      remaining <= remaining - W'(1);
    end
  end
  assign last = remaining == W'(1);
endmodule

// File: rtl/sample_reader.sv
// sample_reader: reads a window of samples around a trigger from a buffer
// and streams them to the host with a valid/ready handshake.
module sample_reader
  import sampler_pkg::*;
#(
  parameter int CNT_BITS = DEF_CNT_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_BITS-1:0]  trig_addr,
  input  logic [CNT_BITS-1:0]  pre_count,
  input  logic [CNT_BITS-1:0]  read_count,
  output logic                 mem_rd_en,
  output logic [CNT_BITS-1:0]  mem_addr,
  input  logic [DATA_BITS-1:0] mem_rd_data,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);
  state_t state, next_state;
  logic load, step, last;
  assign load = state == IDLE && start && !abort;
  assign step = state == OUT && out_ready && !abort;
  rd_addr_counter #(.W(CNT_BITS)) u_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .step      (step),
    .load_addr (trig_addr - pre_count),
    .load_count(read_count),
    .addr      (mem_addr),
    .last      (last)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state;
    if (state == IDLE) next_state = load ? (read_count == '0 ? DONE : FETCH) : IDLE;
    else if (abort) next_state = IDLE;
    else if (state == FETCH) next_state = WAIT;
    else if (state == WAIT) next_state = OUT;
    else if (state == OUT) next_state = out_ready ? (last ? DONE : FETCH) : OUT;
    else next_state = IDLE;
  end
  always_comb begin
    mem_rd_en = state == FETCH;
    out_valid = state == OUT;
    done = state == DONE;
    busy = state != IDLE;
  end
  // an abort while the read is in flight drops the returning data
  always_ff @(posedge clk) begin
    if (!reset_n) out_data <= '0;
    else if (state == WAIT && !abort) out_data <= mem_rd_data;
  end
endmodule

// File: tb/tb_sample_reader.sv
// tb_sample_reader: directed checks of sample_reader with CNT_BITS=4.
module tb_sample_reader;
  logic clk = 0, reset_n = 0, start = 0, abort = 0, out_ready = 0;
  logic [3:0] trig_addr = 0, pre_count = 0, read_count = 0, mem_addr;
  logic [7:0] mem_rd_data = 0, out_data;
  logic mem_rd_en, out_valid, busy, done;
  int total = 0, bad = 0;

  sample_reader #(.CNT_BITS(4), .DATA_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .trig_addr(trig_addr), .pre_count(pre_count), .read_count(read_count),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_rd_data <= mem_rd_en ? {4'h5, mem_addr} : 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_read(input logic [3:0] t, input logic [3:0] p, input logic [3:0] r, input string tag);
    logic [3:0] base, ea;
    int n_rd = 0, n_hs = 0, n_done = 0, done_at = -1, bad_addr = 0, bad_data = 0, bad_gap = 0;
    base = t - p;
    trig_addr = t; pre_count = p; read_count = r; out_ready = 1; start = 1;
    tick();
    start = 0;
    for (int c = 1; c <= 55; c++) begin
      if (mem_rd_en) begin
        ea = base + n_rd[3:0];
        if (mem_addr !== ea) bad_addr++;
        n_rd++;
      end
      if (out_valid && out_ready) begin
        ea = base + n_hs[3:0];
        if (out_data !== {4'h5, ea}) bad_data++;
        if (c != 3 * (n_hs + 1)) bad_gap++;
        n_hs++;
      end
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      tick();
    end
    chk({tag, " reads"}, n_rd, r);
    chk({tag, " handshakes"}, n_hs, r);
    chk({tag, " done pulses"}, n_done, 1);
    chk({tag, " done cycle"}, done_at, 3 * r + 1);
    chk({tag, " addr errs"}, bad_addr, 0);
    chk({tag, " data errs"}, bad_data, 0);
    chk({tag, " gap errs"}, bad_gap, 0);
    chk({tag, " busy end"}, busy, 0);
  endtask

  initial begin
    int hold_bad;
    tick(); tick();
    chk("rst rd_en", mem_rd_en, 0);
    chk("rst valid", out_valid, 0);
    chk("rst done", done, 0);
    chk("rst busy", busy, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst data", out_data, 0);
    reset_n = 1;
    tick();

    run_read(4'd5, 4'd2, 4'd4, "basic");
    run_read(4'd1, 4'd3, 4'd5, "wrap");
    run_read(4'd9, 4'd4, 4'd0, "zero");

    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    chk("abort+start busy", busy, 0);
    tick();
    chk("abort+start busy2", busy, 0);

    // back-pressure: first sample from address 8 held for 10 cycles
    trig_addr = 8; pre_count = 0; read_count = 2; out_ready = 0; start = 1;
    tick();
    start = 0;
    chk("bp fetch addr", mem_addr, 8);
    chk("bp fetch rd_en", mem_rd_en, 1);
    tick(); tick();
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1 || out_data !== 8'h58 || mem_rd_en !== 0) hold_bad++;
      if (i == 4) begin trig_addr = 2; start = 1; end
      if (i == 5) start = 0;
      tick();
    end
    chk("bp hold errs", hold_bad, 0);
    out_ready = 1;
    tick();
    chk("bp next rd_en", mem_rd_en, 1);
    chk("bp next addr", mem_addr, 9);
    tick(); tick();
    chk("bp second valid", out_valid, 1);
    chk("bp second data", out_data, 8'h59);
    tick();
    chk("bp done", done, 1);
    tick();
    chk("bp idle busy", busy, 0);

    trig_addr = 3; pre_count = 0; read_count = 3; start = 1;
    tick();
    start = 0;
    tick();
    abort = 1;
    tick();
    abort = 0;
    hold_bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 0 || done !== 0 || busy !== 0) hold_bad++;
      tick();
    end
    chk("abort quiet errs", hold_bad, 0);
    chk("abort data kept", out_data, 8'h59);
    run_read(4'd10, 4'd1, 4'd2, "restart");

    trig_addr = 7; pre_count = 0; read_count = 3; out_ready = 0; start = 1;
    tick();
    start = 0;
    tick(); tick();
    chk("pre-rst valid", out_valid, 1);
    chk("pre-rst data", out_data, 8'h57);
    reset_n = 0;
    tick();
    chk("mid-rst valid", out_valid, 0);
    chk("mid-rst rd_en", mem_rd_en, 0);
    chk("mid-rst done", done, 0);
    chk("mid-rst busy", busy, 0);
    chk("mid-rst addr", mem_addr, 0);
    chk("mid-rst data", out_data, 0);
    reset_n = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
